// File: rtl/round_controller.sv
// rtl/round_controller.sv - timed-round sequencer driving and observing a countdown timer
//
// Ports:
//   clk, reset            system clock; synchronous active-low reset
//   start                 pulse: begin a game (IDLE/DONE) or the next round (WAIT_NEXT)
//   pause                 pulse: toggle RUN <-> PAUSE
//   answer_valid          pulse: player answered, ends the round early
//   timer_value[15:0]     live ms count from the timer
//   timer_reset           active-high reset to the timer
//   timer_up              timer direction (always countdown)
//   timer_start_value     timer load value (ROUND_MS)
//   timer_max_ms          timer modulus (ROUND_MS+1)
//   timer_enable          timer count enable
//   round_num[7:0]        current round, 0 when idle
//   round_active          high while a round is running or paused
//   warning               time is low in the current round
//   timeout, answered     one-cycle round-end pulses
//   time_left_ms[15:0]    timer value captured at round end
//   score_ms[23:0]        sum of time left over answered rounds
//   game_over             high once the last round has ended

module round_controller #(
    parameter int ROUND_MS   = 10000,
    parameter int WARN_MS    = 3000,
    parameter int NUM_ROUNDS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        answer_valid,
    input  logic [15:0] timer_value,
    output logic        timer_reset,
    output logic        timer_up,
    output logic [15:0] timer_start_value,
    output logic [15:0] timer_max_ms,
    output logic        timer_enable,
    output logic [7:0]  round_num,
    output logic        round_active,
    output logic        warning,
    output logic        timeout,
    output logic        answered,
    output logic [15:0] time_left_ms,
    output logic [23:0] score_ms,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_END,
        S_WAIT_NEXT,
        S_DONE
    } state_t;

    state_t      state, state_d;
    logic        ans_flag, ans_flag_d;
    logic [7:0]  round_d;
    logic [15:0] left_d;
    logic [23:0] score_d;
    logic        warning_d;

    assign timer_up          = 1'b0;
    assign timer_start_value = 16'(ROUND_MS);
    assign timer_max_ms      = 16'(ROUND_MS + 1);

    always_comb begin
        state_d    = state;
        ans_flag_d = ans_flag;
        round_d    = round_num;
        left_d     = time_left_ms;
        score_d    = score_ms;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    round_d = 8'd1;
                    score_d = 24'd0;
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN, S_PAUSE: begin
                // An answer wins over both expiry and pause; on the expiry
                // cycle it simply records the live value, which is 0.
                if (answer_valid) begin
                    state_d    = S_END;
                    ans_flag_d = 1'b1;
                    left_d     = timer_value;
                    score_d    = score_ms + {8'd0, timer_value};
                end else if (state == S_RUN && timer_value == 16'd0) begin
                    state_d    = S_END;
                    ans_flag_d = 1'b0;
                    left_d     = 16'd0;
                end else if (pause) begin
                    state_d = (state == S_RUN) ? S_PAUSE : S_RUN;
                end
            end
            S_END: begin
                state_d = (round_num == 8'(NUM_ROUNDS)) ? S_DONE : S_WAIT_NEXT;
            end
            S_WAIT_NEXT: begin
                if (start) begin
                    state_d = S_LOAD;
                    round_d = round_num + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    assign warning_d = (state_d == S_RUN || state_d == S_PAUSE) &&
                       timer_value != 16'd0 && timer_value <= 16'(WARN_MS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            ans_flag     <= 1'b0;
            round_num    <= 8'd0;
            time_left_ms <= 16'd0;
            score_ms     <= 24'd0;
            timer_reset  <= 1'b1;
            timer_enable <= 1'b0;
            round_active <= 1'b0;
            warning      <= 1'b0;
            timeout      <= 1'b0;
            answered     <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_d;
            ans_flag     <= ans_flag_d;
            round_num    <= round_d;
            time_left_ms <= left_d;
            score_ms     <= score_d;
            timer_reset  <= (state_d == S_IDLE || state_d == S_LOAD || state_d == S_DONE);
            timer_enable <= (state_d == S_RUN);
            round_active <= (state_d == S_RUN || state_d == S_PAUSE);
            warning      <= warning_d;
            timeout      <= (state_d == S_END) && !ans_flag_d;
            answered     <= (state_d == S_END) && ans_flag_d;
            game_over    <= (state_d == S_DONE);
        end
    end

endmodule

// File: doc/round_controller.md
# round_controller

Round sequencer for the game's timed rounds. It sits directly upstream of `timer`, driving its reset, direction, load value, modulus and enable, and directly downstream of it, consuming `timer_value` to detect expiry and warnings. It counts rounds, ends each round on a player answer or on timeout, and accumulates the time left on each answered round as the score.

## Interface
- `ROUND_MS`, default 10000: round length in ms; range 1..65534.
- `WARN_MS`, default 3000: warning threshold in ms; must be less than `ROUND_MS`.
- `NUM_ROUNDS`, default 5: rounds per game; range 1..255.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low (0 = reset), single clock domain.
- `start` in 1: one-cycle pulse; begins a game, or the next round.
- `pause` in 1: one-cycle pulse; toggles between running and paused.
- `answer_valid` in 1: one-cycle pulse; player answered, ends the round early.
- `timer_value` in 16: current ms count from the timer.
- `timer_reset` out 1: active-high synchronous reset to the timer.
- `timer_up` out 1: constant 0 (countdown).
- `timer_start_value` out 16: constant `ROUND_MS`.
- `timer_max_ms` out 16: constant `ROUND_MS+1`.
- `timer_enable` out 1: timer count enable.
- `round_num` out 8: current round, 1..`NUM_ROUNDS`; 0 when idle.
- `round_active` out 1: high in RUN and PAUSE.
- `warning` out 1: time is low in the current round.
- `timeout` out 1: one-cycle pulse when a round expires.
- `answered` out 1: one-cycle pulse when a round ends on an answer.
- `time_left_ms` out 16: `timer_value` captured when the round ends.
- `score_ms` out 24: sum of `time_left_ms` over answered rounds.
- `game_over` out 1: high in DONE.

## Operation
States: IDLE, LOAD, RUN, PAUSE, END, WAIT_NEXT, DONE.

Transitions:
- IDLE: on `start`, set `round_num` to 1, clear `score_ms`, go to LOAD.
- LOAD: lasts one cycle; `timer_reset`=1; go to RUN.
- RUN:
  - `answer_valid`: capture `timer_value` into `time_left_ms`, add it to `score_ms`, set the answer flag, go to END.
  - Else `timer_value`==0: capture 0, set the timeout flag, go to END.
  - Else `pause`: go to PAUSE.
- PAUSE:
  - `pause`: go to RUN.
  - `answer_valid`: handled exactly as in RUN.
  - `timer_value` is frozen here, so no expiry check is needed.
- END: lasts one cycle; pulse `answered` or `timeout` per the flag. If `round_num`==`NUM_ROUNDS`, go to DONE; else go to WAIT_NEXT.
- WAIT_NEXT: on `start`, increment `round_num` and go to LOAD.
- DONE: `game_over`=1; on `start`, behave as IDLE + `start` (round 1, score cleared, go to LOAD).

Output rules:
- `timer_enable`=1 only in RUN.
- `timer_reset`=1 in IDLE, LOAD and DONE, and while `reset`=0.
- `warning` is registered. It is set in RUN/PAUSE when `timer_value`<=`WARN_MS` and `timer_value`!=0. It is cleared in every other state.

Priority and boundaries:
- `answer_valid` beats expiry in the same cycle: records the live `timer_value`, which is 0 on the expiry cycle, so `answered` pulses with `time_left_ms`=0 and score unchanged.
- `answer_valid` beats `pause`.
- `start` is ignored in LOAD, RUN, PAUSE and END.
- `pause` and `answer_valid` are ignored outside RUN/PAUSE.
- `score_ms` cannot overflow: 255×65534 < 2^24.
- Reset mid-game: all state returns to reset values next edge and the timer is held in reset. No `timeout` or `answered` pulse is emitted.

## Timing
- Reset values: state IDLE, `round_num` 0, `time_left_ms` 0, `score_ms` 0; `timer_reset` 1; `timer_enable`, `round_active`, `warning`, `timeout`, `answered`, `game_over` all 0.
- All outputs are registered except the constants `timer_up`, `timer_start_value` and `timer_max_ms`.
- Round start: `start` at edge N → LOAD at N+1 (`timer_reset` high) → timer loads `ROUND_MS` at N+2 and RUN begins at N+2 with `timer_enable`=1.
- Expiry: the first RUN cycle sampling `timer_value`==0 → END on the next edge → `timeout` high for exactly one cycle, with `round_active` low in that same cycle.
- `answered` is likewise one cycle, in END.
- `warning` lags `timer_value` by one cycle.

## Test plan
Bench: the timer is instantiated with CLKS_PER_MS=4; parameters `ROUND_MS`=5, `WARN_MS`=2, `NUM_ROUNDS`=2.

- Reset then idle 20 cycles → `timer_reset`=1, `timer_enable`=0, `round_num`=0, all pulses low.
- `start`, no input → `timer_value` counts 5→0; `warning` rises one cycle after `timer_value`=2; `timeout` pulses once with `time_left_ms`=0; state WAIT_NEXT with `round_num`=1.
- Round 2: `answer_valid` when `timer_value`=3 → `answered` pulse, `time_left_ms`=3, `score_ms`=3, `game_over`=1; `start` in DONE → `round_num`=1, `score_ms`=0.
- `pause` at `timer_value`=4, hold 40 cycles → `timer_value` stays 4 and `timer_enable`=0; second `pause` → countdown resumes from 4.
- `answer_valid` in the same cycle that `timer_value`=0 is sampled in RUN → `answered` (not `timeout`), `time_left_ms`=0, `score_ms` unchanged.
- `reset`=0 for one cycle mid-RUN at `timer_value`=3 → next cycle state IDLE, `score_ms`=0, `round_num`=0, no `timeout` or `answered` pulse.
